// File: rtl/rf_wb_arbiter.sv
// Round-robin write-back arbiter for the register file, plus the busy scoreboard
// used by the issue stage to stall on read-after-write hazards.
//
// Ports:
//   CLK, RST          clock; asynchronous active-high reset
//   WB_EN             global write-back enable (no grants while low)
//   REQ_VALID/READY   per-requester handshake (READY is a one-hot combinational grant)
//   REQ_ADDR/DATA     packed per-requester destination address and write data
//   WE/WADDR/WDATA    registered register-file write port, one-cycle strobe
//   SB_SET/SB_ADDR    issue stage marks a destination register as pending
//   SB_ACCEPT         the mark is taken this cycle
//   BUSY              one pending bit per register
module rf_wb_arbiter #(
    parameter int NREQ = 3,
    parameter int DW   = 8,
    parameter int AW   = 2
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 WB_EN,
    input  logic [NREQ-1:0]      REQ_VALID,
    output logic [NREQ-1:0]      REQ_READY,
    input  logic [NREQ*AW-1:0]   REQ_ADDR,
    input  logic [NREQ*DW-1:0]   REQ_DATA,
    output logic                 WE,
    output logic [AW-1:0]        WADDR,
    output logic [DW-1:0]        WDATA,
    input  logic                 SB_SET,
    input  logic [AW-1:0]        SB_ADDR,
    output logic                 SB_ACCEPT,
    output logic [(1<<AW)-1:0]   BUSY
);

    localparam int RW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [RW:0]   NREQ_W = (RW+1)'(NREQ);
    localparam logic [RW-1:0] LAST   = RW'(NREQ - 1);

    logic [RW-1:0]       rr;
    logic [RW-1:0]       rr_nxt;
    logic [RW-1:0]       win;
    logic                found;
    logic                xfer;
    logic [AW-1:0]       win_addr;
    logic [DW-1:0]       win_data;
    logic [NREQ*AW-1:0]  addr_sh;
    logic [NREQ*DW-1:0]  data_sh;
    logic [(1<<AW)-1:0]  busy_nxt;

    // Scan from rr upward, wrapping modulo NREQ; first valid requester wins.
    always_comb begin : arb
        logic [RW:0]     sum;
        logic [NREQ-1:0] vsh;
        found = 1'b0;
        win   = '0;
        sum   = '0;
        vsh   = '0;
        for (int k = 0; k < NREQ; k++) begin
            sum = {1'b0, rr} + (RW+1)'(k);
            if (sum >= NREQ_W) begin
                sum = sum - NREQ_W;
            end
            vsh = REQ_VALID >> sum[RW-1:0];
            if (!found && vsh[0]) begin
                found = 1'b1;
                win   = sum[RW-1:0];
            end
        end
    end

    assign xfer      = found & WB_EN;
    assign REQ_READY = xfer ? (NREQ'(1) << win) : '0;
    assign addr_sh   = REQ_ADDR >> (int'(win) * AW);
    assign data_sh   = REQ_DATA >> (int'(win) * DW);
    assign win_addr  = addr_sh[AW-1:0];
    assign win_data  = data_sh[DW-1:0];
    assign rr_nxt    = (win == LAST) ? '0 : win + 1'b1;

    // A mark on a busy register is still taken when that register's
    // pending write commits on this very edge (back-to-back producers).
    assign SB_ACCEPT = SB_SET &
                       (~BUSY[SB_ADDR] | (xfer & (win_addr == SB_ADDR)));

    // Clear first, then set, so a same-register set/clear leaves it busy.
    always_comb begin
        busy_nxt = BUSY;
        if (xfer) begin
            busy_nxt[win_addr] = 1'b0;
        end
        if (SB_ACCEPT) begin
            busy_nxt[SB_ADDR] = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            WE    <= 1'b0;
            WADDR <= '0;
            WDATA <= '0;
            BUSY  <= '0;
            rr    <= '0;
        end else begin
            WE   <= xfer;
            BUSY <= busy_nxt;
            if (xfer) begin
                WADDR <= win_addr;
                WDATA <= win_data;
                rr    <= rr_nxt;
            end
        end
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: reference model of the round-robin
// pointer and busy bits, with a queue of expected register-file writes.
module tb_rf_wb_arbiter;

    logic       CLK;
    logic       RST;
    logic       WB_EN;
    logic [2:0] REQ_VALID;
    logic [2:0] REQ_READY;
    logic [5:0] REQ_ADDR;
    logic [23:0] REQ_DATA;
    logic       WE;
    logic [1:0] WADDR;
    logic [7:0] WDATA;
    logic       SB_SET;
    logic [1:0] SB_ADDR;
    logic       SB_ACCEPT;
    logic [3:0] BUSY;

    logic [1:0] a [3];
    logic [7:0] d [3];

    assign REQ_ADDR = {a[2], a[1], a[0]};
    assign REQ_DATA = {d[2], d[1], d[0]};

    rf_wb_arbiter #(.NREQ(3), .DW(8), .AW(2)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .WB_EN     (WB_EN),
        .REQ_VALID (REQ_VALID),
        .REQ_READY (REQ_READY),
        .REQ_ADDR  (REQ_ADDR),
        .REQ_DATA  (REQ_DATA),
        .WE        (WE),
        .WADDR     (WADDR),
        .WDATA     (WDATA),
        .SB_SET    (SB_SET),
        .SB_ADDR   (SB_ADDR),
        .SB_ACCEPT (SB_ACCEPT),
        .BUSY      (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [1:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t        exp_q [$];
    int         m_rr;
    logic [3:0] m_busy;
    int         checks;
    int         failures;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: entered just after a falling edge with inputs driven.
    // exp_w: requester that must be granted (-1 = none).
    // exp_acc: required SB_ACCEPT (-1 = take the model's value only).
    task automatic cycle(input string tag, input int exp_w, input int exp_acc);
        bit   found;
        bit   g;
        bit   acc;
        int   w;
        int   i;
        wr_t  e;
        found = 0;
        w     = 0;
        #1;
        for (int k = 0; k < 3; k++) begin
            i = (m_rr + k) % 3;
            if (!found && REQ_VALID[i]) begin
                found = 1;
                w     = i;
            end
        end
        g   = found && WB_EN;
        acc = SB_SET && (!m_busy[SB_ADDR] || (g && a[w] == SB_ADDR));
        chk({tag, ".ready_model"}, REQ_READY, g ? (3'b001 << w) : 3'b000);
        chk({tag, ".grant"}, REQ_READY, (exp_w < 0) ? 3'b000 : (3'b001 << exp_w));
        chk({tag, ".sb_accept"}, SB_ACCEPT, acc);
        if (exp_acc >= 0) begin
            chk({tag, ".sb_accept_dir"}, SB_ACCEPT, exp_acc[0]);
        end
        if (g) begin
            exp_q.push_back('{addr: a[w], data: d[w]});
        end
        @(posedge CLK);
        if (g) begin
            m_busy[a[w]] = 1'b0;
            m_rr         = (w + 1) % 3;
        end
        if (acc) begin
            m_busy[SB_ADDR] = 1'b1;
        end
        #1;
        if (g) begin
            if (exp_q.size() == 0) begin
                chk({tag, ".queue_empty"}, 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk({tag, ".we"}, WE, 1'b1);
                chk({tag, ".waddr"}, WADDR, e.addr);
                chk({tag, ".wdata"}, WDATA, e.data);
            end
        end else begin
            chk({tag, ".we_idle"}, WE, 1'b0);
        end
        chk({tag, ".busy"}, BUSY, m_busy);
        @(negedge CLK);
    endtask

    task automatic set_req(input int i, input logic [1:0] addr,
                           input logic [7:0] data);
        a[i] = addr;
        d[i] = data;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        m_rr      = 0;
        m_busy    = '0;
        RST       = 1'b1;
        WB_EN     = 1'b1;
        REQ_VALID = 3'b000;
        SB_SET    = 1'b0;
        SB_ADDR   = 2'd0;
        set_req(0, 2'd1, 8'hA1);
        set_req(1, 2'd2, 8'hB2);
        set_req(2, 2'd3, 8'hC3);

        @(negedge CLK);
        chk("rst.we", WE, 1'b0);
        chk("rst.waddr", WADDR, 2'd0);
        chk("rst.wdata", WDATA, 8'h00);
        chk("rst.busy", BUSY, 4'b0000);
        RST = 1'b0;

        // all three valid: grants rotate 0,1,2,0,1,2
        REQ_VALID = 3'b111;
        cycle("rr0", 0, -1);
        cycle("rr1", 1, -1);
        cycle("rr2", 2, -1);
        cycle("rr3", 0, -1);
        cycle("rr4", 1, -1);
        cycle("rr5", 2, -1);

        // write-back disabled with requester 1 waiting
        REQ_VALID = 3'b010;
        WB_EN     = 1'b0;
        cycle("stall0", -1, -1);
        cycle("stall1", -1, -1);
        cycle("stall2", -1, -1);
        WB_EN = 1'b1;
        cycle("stall_rel", 1, -1);
        REQ_VALID = 3'b000;
        cycle("stall_wr", -1, -1);

        // scoreboard hazard on register 2
        SB_SET  = 1'b1;
        SB_ADDR = 2'd2;
        cycle("sb_set", -1, 1);
        chk("sb_set.busy_dir", BUSY, 4'b0100);
        cycle("sb_again", -1, 0);
        chk("sb_again.busy_dir", BUSY, 4'b0100);
        SB_SET    = 1'b0;
        REQ_VALID = 3'b001;
        set_req(0, 2'd2, 8'h77);
        cycle("sb_clr", 0, -1);
        chk("sb_clr.busy_dir", BUSY, 4'b0000);

        // same-register set and clear: set wins
        REQ_VALID = 3'b000;
        SB_SET    = 1'b1;
        SB_ADDR   = 2'd3;
        cycle("sc_mark", -1, 1);
        REQ_VALID = 3'b010;
        set_req(1, 2'd3, 8'h3C);
        cycle("sc_same", 1, 1);
        chk("sc_same.busy_dir", BUSY, 4'b1000);

        // different registers on the same edge: both apply
        REQ_VALID = 3'b001;
        set_req(0, 2'd1, 8'h11);
        SB_ADDR = 2'd2;
        cycle("sc_diff", 0, 1);
        chk("sc_diff.busy_dir", BUSY, 4'b1100);
        SB_SET = 1'b0;

        // lone requester 2 is granted at once; pointer wraps to 0
        REQ_VALID = 3'b100;
        set_req(2, 2'd0, 8'h5A);
        cycle("single", 2, -1);
        chk("single.waddr_dir", WADDR, 2'd0);
        chk("single.wdata_dir", WDATA, 8'h5A);
        REQ_VALID = 3'b111;
        set_req(0, 2'd1, 8'hA1);
        set_req(1, 2'd2, 8'hB2);
        set_req(2, 2'd3, 8'hC3);
        cycle("wrap", 0, -1);

        // asynchronous reset mid-cycle with all requesters valid
        #2;
        RST = 1'b1;
        #1;
        chk("arst.we", WE, 1'b0);
        chk("arst.waddr", WADDR, 2'd0);
        chk("arst.wdata", WDATA, 8'h00);
        chk("arst.busy", BUSY, 4'b0000);
        m_rr   = 0;
        m_busy = '0;
        exp_q.delete();
        @(negedge CLK);
        RST = 1'b0;
        cycle("post_rst", 0, -1);
        REQ_VALID = 3'b000;
        cycle("post_rst_wr", -1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
